// File: rtl/processor_pkg.sv
// Shared definitions for the single-cycle load/store core: widths, opcodes,
// instruction field positions and an instruction encoder for ROM images.
package processor_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 16;
  localparam int REG_AW    = 4;
  localparam int OP_W      = 6;
  localparam int IMM_W     = 14;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 18;
  localparam int RT_HI  = 17;
  localparam int RT_LO  = 14;
  localparam int IMM_HI = 13;
  localparam int IMM_LO = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
  localparam logic [OP_W-1:0] OP_AND  = 6'd3;
  localparam logic [OP_W-1:0] OP_OR   = 6'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd5;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd6;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd7;
  localparam logic [OP_W-1:0] OP_LW   = 6'd8;
  localparam logic [OP_W-1:0] OP_SW   = 6'd9;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd10;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd11;
  localparam logic [OP_W-1:0] OP_JMP  = 6'd12;
  localparam logic [OP_W-1:0] OP_HALT = 6'd13;

  function automatic logic [XLEN-1:0] encode(
    input logic [OP_W-1:0]   op,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rt,
    input logic [IMM_W-1:0]  imm
  );
    return {op, rd, rs, rt, imm};
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM: combinational read, write at the clock edge,
// whole array cleared by synchronous reset.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] ram [DEPTH];

  // Power-on contents match the post-reset contents.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (we) begin
      ram[addr] <= wdata;
    end
  end

  assign rdata = ram[addr];

endmodule

// File: rtl/processor_core.sv
// Single-cycle 32-bit load/store core: fetch, decode, execute and register
// read are combinational; pc, register file and RAM all update on one edge.
module processor_core
  import processor_pkg::*;
#(
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256,
  parameter string IMEM_FILE  = ""
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            halted
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [XLEN-1:0]   imem [IMEM_DEPTH];
  logic [XLEN-1:0]   regs_q [REG_COUNT];
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;

  logic [XLEN-1:0]   instr;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd, rs, rt;
  logic [IMM_W-1:0]  imm;
  logic [XLEN-1:0]   imm_sx, imm_zx;
  logic [XLEN-1:0]   rs_val, rt_val;
  logic signed [XLEN-1:0] rs_s, rt_s;
  logic [XLEN-1:0]   wb_val;
  logic              reg_we, mem_we;
  logic [DAW-1:0]    dmem_addr;
  logic [XLEN-1:0]   mem_rdata;

  // The ROM holds the built-in demo program.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
    imem[0] = encode(OP_ADDI, 4'd1, 4'd0, 4'd0, 14'd5);
    imem[1] = encode(OP_ADDI, 4'd2, 4'd0, 4'd0, 14'd7);
    imem[2] = encode(OP_ADD,  4'd3, 4'd1, 4'd2, 14'd0);
    imem[3] = encode(OP_SW,   4'd0, 4'd0, 4'd3, 14'd2);
    imem[4] = encode(OP_SUB,  4'd4, 4'd2, 4'd1, 14'd0);
    imem[5] = encode(OP_SW,   4'd0, 4'd0, 4'd4, 14'd3);
    imem[6] = encode(OP_HALT, 4'd0, 4'd0, 4'd0, 14'd0);
  end

  assign instr  = imem[pc_q[IAW-1:0]];
  assign op     = instr[OP_HI:OP_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign imm    = instr[IMM_HI:IMM_LO];
  assign imm_sx = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zx = {{(XLEN-IMM_W){1'b0}}, imm};

  // r0 is hardwired to zero on the read side as well as the write side.
  assign rs_val = (rs == '0) ? '0 : regs_q[rs];
  assign rt_val = (rt == '0) ? '0 : regs_q[rt];
  assign rs_s   = rs_val;
  assign rt_s   = rt_val;

  assign dmem_addr = rs_val[DAW-1:0] + imm_sx[DAW-1:0];

  always_comb begin
    wb_val = '0;
    reg_we = 1'b0;
    mem_we = 1'b0;
    case (op)
      OP_ADD:  begin wb_val = rs_val + rt_val;                reg_we = 1'b1; end
      OP_SUB:  begin wb_val = rs_val - rt_val;                reg_we = 1'b1; end
      OP_AND:  begin wb_val = rs_val & rt_val;                reg_we = 1'b1; end
      OP_OR:   begin wb_val = rs_val | rt_val;                reg_we = 1'b1; end
      OP_XOR:  begin wb_val = rs_val ^ rt_val;                reg_we = 1'b1; end
      OP_SLT:  begin wb_val = (rs_s < rt_s) ? 32'd1 : 32'd0; reg_we = 1'b1; end
      OP_ADDI: begin wb_val = rs_val + imm_sx;                reg_we = 1'b1; end
      OP_LW:   begin wb_val = mem_rdata;                      reg_we = 1'b1; end
      OP_SW:   mem_we = 1'b1;
      default: ;
    endcase
    if (halted_q) begin
      reg_we = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_comb begin
    pc_d     = pc_q + 32'd1;
    halted_d = halted_q;
    if (halted_q) begin
      pc_d = pc_q;
    end else begin
      case (op)
        OP_BEQ:  if (rs_val == rt_val) pc_d = pc_q + 32'd1 + imm_sx;
        OP_BNE:  if (rs_val != rt_val) pc_d = pc_q + 32'd1 + imm_sx;
        OP_JMP:  pc_d = imm_zx;
        OP_HALT: begin
          pc_d     = pc_q;
          halted_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (reg_we && (rd != '0)) begin
      regs_q[rd] <= wb_val;
    end
  end

  data_mem #(
    .DEPTH (DMEM_DEPTH),
    .WIDTH (XLEN)
  ) datamem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (dmem_addr),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  assign pc     = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_processor_core.sv
// Directed bench for processor_core: default program, mid-run reset and
// small hand-assembled programs loaded into the ROM.
module tb_processor_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        halted;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog [$];

  processor_core dut (
    .clk    (clk),
    .rst    (rst),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input int op, input int rd, input int rs,
                                      input int rt, input int imm);
    logic [31:0] w;
    w = {op[5:0], rd[3:0], rs[3:0], rt[3:0], imm[13:0]};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic load_prog;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ram2", dut.datamem.ram[2], 32'd0);

    // Default program
    step(3);
    chk("def_ram2_e3", dut.datamem.ram[2], 32'd0);
    step(1);
    chk("def_ram2_e4", dut.datamem.ram[2], 32'd12);
    step(2);
    chk("def_ram3_e6", dut.datamem.ram[3], 32'd2);
    chk("def_pc_e6", pc, 32'd6);
    chk("def_halt_e6", {31'd0, halted}, 32'd0);
    step(1);
    chk("def_halt_e7", {31'd0, halted}, 32'd1);
    step(3);
    chk("def_ram2", dut.datamem.ram[2], 32'd12);
    chk("def_ram3", dut.datamem.ram[3], 32'd2);
    chk("def_r3", dut.regs_q[3], 32'd12);
    chk("def_r4", dut.regs_q[4], 32'd2);
    chk("def_halted", {31'd0, halted}, 32'd1);
    chk("def_pc", pc, 32'd6);

    // Reset mid-run: after edge 3, before the SW at word 3 commits
    do_reset();
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_pc", pc, 32'd0);
    chk("mid_ram2", dut.datamem.ram[2], 32'd0);
    for (int i = 1; i <= 4; i++) chk($sformatf("mid_r%0d", i), dut.regs_q[i], 32'd0);
    step(10);
    chk("rerun_ram2", dut.datamem.ram[2], 32'd12);
    chk("rerun_ram3", dut.datamem.ram[3], 32'd2);
    chk("rerun_pc", pc, 32'd6);
    chk("rerun_halted", {31'd0, halted}, 32'd1);

    // r0 immutable, plus effective address wrapping modulo 256
    prog = '{enc(7, 0, 0, 0, 9),
             enc(9, 0, 0, 0, 5),
             enc(7, 2, 0, 0, 300),
             enc(9, 0, 0, 2, 258),
             enc(13, 0, 0, 0, 0)};
    load_prog();
    step(8);
    chk("r0_ram5", dut.datamem.ram[5], 32'd0);
    chk("r0_reg", dut.regs_q[0], 32'd0);
    chk("wrap_ram2", dut.datamem.ram[2], 32'd300);

    // Branch loop
    prog = '{enc(7, 1, 0, 0, 3),
             enc(7, 1, 1, 0, -1),
             enc(11, 0, 1, 0, -2),
             enc(9, 0, 0, 1, 1),
             enc(13, 0, 0, 0, 0)};
    load_prog();
    dut.datamem.ram[1] = 32'hDEAD;
    step(8);
    chk("loop_halt_e8", {31'd0, halted}, 32'd0);
    chk("loop_ram1", dut.datamem.ram[1], 32'd0);
    step(1);
    chk("loop_halt_e9", {31'd0, halted}, 32'd1);
    chk("loop_pc", pc, 32'd4);

    // LW / SLT / wrap-around arithmetic
    prog = '{enc(7, 1, 0, 0, -1),
             enc(7, 2, 1, 0, 1),
             enc(6, 3, 1, 0, 0),
             enc(9, 0, 0, 1, 4),
             enc(8, 5, 0, 0, 4),
             enc(6, 6, 0, 1, 0),
             enc(13, 0, 0, 0, 0)};
    load_prog();
    step(10);
    chk("lw_r2", dut.regs_q[2], 32'd0);
    chk("slt_r3", dut.regs_q[3], 32'd1);
    chk("sw_ram4", dut.datamem.ram[4], 32'hFFFF_FFFF);
    chk("lw_r5", dut.regs_q[5], 32'hFFFF_FFFF);
    chk("slt_r6", dut.regs_q[6], 32'd0);

    // JMP, BEQ, and freeze after HALT
    prog = '{enc(7, 1, 0, 0, 7),
             enc(12, 0, 0, 0, 3),
             enc(9, 0, 0, 1, 6),
             enc(10, 0, 1, 0, 5),
             enc(10, 0, 0, 0, 1),
             enc(9, 0, 0, 1, 9),
             enc(9, 0, 0, 1, 10),
             enc(13, 0, 0, 0, 0),
             enc(9, 0, 0, 1, 7)};
    load_prog();
    step(6);
    chk("jmp_halted", {31'd0, halted}, 32'd1);
    chk("jmp_pc_halt", pc, 32'd7);
    step(5);
    chk("jmp_pc_hold", pc, 32'd7);
    chk("jmp_skip_ram6", dut.datamem.ram[6], 32'd0);
    chk("beq_skip_ram9", dut.datamem.ram[9], 32'd0);
    chk("beq_tgt_ram10", dut.datamem.ram[10], 32'd7);
    chk("post_halt_ram7", dut.datamem.ram[7], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
